// File: rtl/mux_rr_reg_pkg.sv
// Shared constants and types for the registered round-robin multiplexer.
package mux_pkg;

  // Selection mode encodings for the 'mode' input.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Default geometry used when the top level is not overridden.
  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHANNELS = 4;

  // Output register occupancy; FULL is exactly the out_valid condition.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/mux_rr_reg_rr_arbiter.sv
// Purely combinational rotating-priority search: finds the first requesting
// channel after 'ptr', wrapping around and ending with 'ptr' itself.
module rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                found,
  output logic [SEL_W-1:0]    idx
);

  // Scan candidates (ptr+1) .. (ptr+CHANNELS) modulo CHANNELS; first hit wins.
  // The inner loop compares against constant indices so req is never indexed
  // by a wide runtime value.
  always_comb begin
    int cand;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = (int'(ptr) + k) % CHANNELS;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && (cand == i) && req[i]) begin
          found = 1'b1;
          idx   = SEL_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel, W-bit registered multiplexer with manual or round-robin channel
// choice, a one-hot combinational grant to the source, and a valid/ready
// output register.
//
// Handshake: the consumer takes out_data/out_chan on any rising edge where
// out_valid && out_ready; while out_valid=1 and out_ready=0 the outputs hold.
// A producer's word is consumed on the edge where its grant bit is 1; until
// then it must hold in_data/in_req, and dropping in_req withdraws the offer.
module mux_rr_reg
  import mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_req,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       grant,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic             man_found;
  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic [WIDTH-1:0] win_word;

  // Round-robin candidate; evaluated every cycle regardless of mode so a
  // mode change takes effect immediately.
  rr_arbiter #(
    .CHANNELS(CHANNELS)
  ) u_rr_arbiter (
    .req  (in_req),
    .ptr  (ptr_q),
    .found(rr_found),
    .idx  (rr_idx)
  );

  // Manual decode: sel must name an existing channel that is requesting.
  // Out-of-range sel values (possible when CHANNELS is not a power of two)
  // simply never match.
  always_comb begin
    man_found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((32'(sel) == 32'(i)) && in_req[i]) begin
        man_found = 1'b1;
      end
    end
  end

  // Winner selection and load-enable: the register accepts when empty or
  // being drained on this edge.
  always_comb begin
    load_en   = (state_q == ST_EMPTY) || out_ready;
    win_found = (mode == MODE_RR) ? rr_found : man_found;
    win_idx   = (mode == MODE_RR) ? rr_idx : sel;
  end

  // Data mux for the winning channel's word.
  always_comb begin
    win_word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (win_idx == SEL_W'(i)) begin
        win_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot grant; forced low during reset because reset discards the load.
  always_comb begin
    grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      grant[i] = !reset && load_en && win_found && (win_idx == SEL_W'(i));
    end
  end

  // Next-state: load on a grant, go empty when loadable with no winner,
  // otherwise hold (stalled FULL). ptr follows grants in both modes.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (win_found) begin
        state_d = ST_FULL;
        data_d  = win_word;
        chan_d  = win_idx;
        ptr_d   = win_idx;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // Output register and round-robin pointer; ptr resets to the last channel
  // so the first round-robin search starts at channel 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= SEL_W'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  // Registered outputs; out_valid is the FULL state itself.
  always_comb begin
    out_valid = (state_q == ST_FULL);
    out_data  = data_q;
    out_chan  = chan_q;
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: a 4-channel instance for reset, manual,
// round-robin, backpressure and mid-operation reset, and a 3-channel
// instance for invalid select and mode switching.
module tb_mux_rr_reg;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 4-channel DUT ----------------
  logic [15:0] data4;
  logic [3:0]  req4;
  logic        mode4;
  logic [1:0]  sel4;
  logic        rdy4;
  logic [3:0]  grant4;
  logic [3:0]  odata4;
  logic [1:0]  ochan4;
  logic        ovalid4;

  mux_rr_reg #(.WIDTH(4), .CHANNELS(4)) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .in_data  (data4),
    .in_req   (req4),
    .mode     (mode4),
    .sel      (sel4),
    .out_ready(rdy4),
    .grant    (grant4),
    .out_data (odata4),
    .out_chan (ochan4),
    .out_valid(ovalid4)
  );

  // ---------------- 3-channel DUT ----------------
  logic [11:0] data3;
  logic [2:0]  req3;
  logic        mode3;
  logic [1:0]  sel3;
  logic        rdy3;
  logic [2:0]  grant3;
  logic [3:0]  odata3;
  logic [1:0]  ochan3;
  logic        ovalid3;

  mux_rr_reg #(.WIDTH(4), .CHANNELS(3)) u_dut3 (
    .clk      (clk),
    .reset    (reset),
    .in_data  (data3),
    .in_req   (req3),
    .mode     (mode3),
    .sel      (sel3),
    .out_ready(rdy3),
    .grant    (grant3),
    .out_data (odata3),
    .out_chan (ochan3),
    .out_valid(ovalid3)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full registered output of the 4-channel DUT.
  task automatic chk_out4(input string tag, input logic v, input logic [3:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(ovalid4), 32'(v));
    chk({tag, ".data"},  32'(odata4),  32'(d));
    chk({tag, ".chan"},  32'(ochan4),  32'(c));
  endtask

  logic [1:0] rr_all [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] rr_alt [4] = '{2'd1, 2'd3, 2'd1, 2'd3};

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    data4 = {4'h4, 4'h3, 4'h2, 4'h1};
    req4  = 4'b1111;
    mode4 = 1'b1;
    sel4  = 2'd0;
    rdy4  = 1'b1;
    data3 = {4'hC, 4'hB, 4'h9};
    req3  = 3'b000;
    mode3 = 1'b0;
    sel3  = 2'd0;
    rdy3  = 1'b1;

    // Reset held 2 cycles with every channel requesting.
    #1;
    chk("rst.grant0", 32'(grant4), 32'h0);
    step();
    chk_out4("rst.c1", 1'b0, 4'h0, 2'd0);
    chk("rst.grant1", 32'(grant4), 32'h0);
    step();
    chk_out4("rst.c2", 1'b0, 4'h0, 2'd0);
    chk("rst.grant2", 32'(grant4), 32'h0);
    chk("rst.valid3", 32'(ovalid3), 32'h0);
    reset = 1'b0;
    #1;
    chk("rr.first_grant", 32'(grant4), 32'b0001);
    step();
    chk_out4("rr.first", 1'b1, 4'h1, 2'd0);

    // Round-robin over all channels, no idle cycles.
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr.all.valid", 32'(ovalid4), 32'h1);
      chk("rr.all.chan", 32'(ochan4), 32'(rr_all[k]));
    end

    // Round-robin over channels 1 and 3.
    req4 = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr.alt.valid", 32'(ovalid4), 32'h1);
      chk("rr.alt.chan", 32'(ochan4), 32'(rr_alt[k]));
    end

    // Manual select of channel 2.
    mode4 = 1'b0;
    sel4  = 2'd2;
    req4  = 4'b0100;
    data4 = {4'h4, 4'hA, 4'h2, 4'h1};
    #1;
    chk("man.grant", 32'(grant4), 32'b0100);
    step();
    chk_out4("man.load", 1'b1, 4'hA, 2'd2);
    req4 = 4'b0000;
    #1;
    chk("man.nogrant", 32'(grant4), 32'h0);
    step();
    chk_out4("man.empty", 1'b0, 4'hA, 2'd2);

    // Backpressure: load ch1 (5), then stall while ch2 requests.
    sel4  = 2'd1;
    req4  = 4'b0010;
    data4 = {4'h4, 4'hA, 4'h5, 4'h1};
    step();
    chk_out4("bp.load1", 1'b1, 4'h5, 2'd1);
    mode4 = 1'b1;
    rdy4  = 1'b0;
    req4  = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp.stall.grant", 32'(grant4), 32'h0);
      step();
      chk_out4("bp.stall", 1'b1, 4'h5, 2'd1);
    end
    rdy4 = 1'b1;
    #1;
    chk("bp.release.grant", 32'(grant4), 32'b0100);
    step();
    chk_out4("bp.release", 1'b1, 4'hA, 2'd2);

    // Reset mid-operation: FULL, stalled, with pending requests.
    rdy4 = 1'b0;
    req4 = 4'b1100;
    step();
    chk_out4("mid.stall", 1'b1, 4'hA, 2'd2);
    reset = 1'b1;
    #1;
    chk("mid.rst.grant", 32'(grant4), 32'h0);
    step();
    reset = 1'b0;
    chk_out4("mid.cleared", 1'b0, 4'h0, 2'd0);
    rdy4 = 1'b1;
    #1;
    chk("mid.next.grant", 32'(grant4), 32'b0100);
    step();
    chk_out4("mid.next", 1'b1, 4'hA, 2'd2);

    // 3 channels: out-of-range manual select never grants.
    mode3 = 1'b0;
    sel3  = 2'd3;
    req3  = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("c3.badsel.grant", 32'(grant3), 32'h0);
      step();
      chk("c3.badsel.valid", 32'(ovalid3), 32'h0);
    end
    sel3 = 2'd1;
    #1;
    chk("c3.man1.grant", 32'(grant3), 32'b010);
    step();
    chk("c3.man1.chan", 32'(ochan3), 32'd1);
    chk("c3.man1.data", 32'(odata3), 32'hB);
    mode3 = 1'b1;
    #1;
    chk("c3.switch.grant", 32'(grant3), 32'b100);
    step();
    chk("c3.switch.chan", 32'(ochan3), 32'd2);
    chk("c3.switch.data", 32'(odata3), 32'hC);
    chk("c3.switch.valid", 32'(ovalid3), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
# mux_rr_reg

Parametrised N-channel, W-bit registered multiplexer with a valid/ready output handshake. It is the sequential successor of the team's 2:1 gate-level mux. A channel is chosen in one of two modes: manual (external select) or round-robin among requesting channels. The chosen word is captured into an output register, and the source channel gets a one-cycle grant. It sits between several producers and a single consumer in the datapath lab designs.

## Interface
- `WIDTH`, default 4: data width per channel; must be ≥1.
- `CHANNELS`, default 4: number of input channels; must be ≥2.
- `SEL_W`, default `$clog2(CHANNELS)`: width of the select and channel-id fields; derived, never overridden.

Ports:
- `clk`  in  1  single clock; rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_req`  in  CHANNELS  channel i has a word to offer.
- `mode`  in  1  0 = manual select, 1 = round-robin.
- `sel`  in  SEL_W  channel index used in manual mode.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `grant`  out  CHANNELS  one-hot, combinational; channel i's word is captured at this edge.
- `out_data`  out  WIDTH  registered data.
- `out_chan`  out  SEL_W  registered index of the source of `out_data`.
- `out_valid`  out  1  `out_data` and `out_chan` are valid.

## Operation
- The output register has two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `load_en` = !out_valid || out_ready. The register can take a new word when it is empty or being drained this cycle.
- Winner selection, evaluated every cycle:
  - Manual mode: winner = `sel`, if `sel` < CHANNELS and `in_req[sel]`=1. Otherwise there is no winner.
  - Round-robin mode: winner = first i with `in_req[i]`=1, scanning (ptr+1) mod CHANNELS, (ptr+2) mod CHANNELS, … up to ptr. The scan wraps around.
- `grant[winner]`=1 only when `load_en`=1 and a winner exists. Otherwise `grant`=0.
- On a clock edge with a grant:
  - `out_data` ← winner's word.
  - `out_chan` ← winner.
  - `out_valid` ← 1.
  - `ptr` ← winner.
- On a clock edge with `load_en`=1 and no winner: `out_valid` ← 0. `out_data` and `out_chan` hold their old values.
- On a clock edge with `load_en`=0 (FULL and stalled): all outputs hold, and `grant`=0.
- `ptr` is updated on grants in both modes. This keeps round-robin fair after a mode switch.
- A `mode` change takes effect in the same cycle's selection. No draining is required.
- Reset overrides everything, including a transfer that is mid-handshake:
  - `out_valid`=0, `out_data`=0, `out_chan`=0.
  - `ptr`=CHANNELS-1, so the first round-robin search starts at channel 0.
  - `grant`=0 while `reset`=1.

## Timing
- Latency is 1 cycle: a grant at edge k gives `out_valid`=1 with the data after edge k.
- Throughput is 1 word/cycle when `out_ready` is held high and any request is present.
- Simultaneous drain and load: if FULL with `out_ready`=1 and a winner exists, the register is replaced with no bubble.
- Producers must hold `in_data`/`in_req` stable until they see their grant. Dropping `in_req` before the grant withdraws the offer.
- The consumer samples on `out_valid && out_ready`. Data is guaranteed stable while `out_valid=1 && out_ready=0`.
- Combinational path: `in_req`, `sel`, `mode`, `out_ready` → `grant`. There is no path from an input to `out_*`.

## Structure
- Shared package `mux_pkg`:
  - `MODE_MANUAL`=1'b0, `MODE_RR`=1'b1 constants.
  - Default `WIDTH`/`CHANNELS` localparams.
- Sub-module `rr_arbiter`:
  - Parameter `CHANNELS`.
  - Inputs `req`, `ptr`.
  - Outputs `found`, `idx`.
  - Purely combinational rotating priority search.
- The top level holds `ptr`, the output register, manual-mode decode and grant generation.

## Test plan
- Reset behaviour: assert `reset` for 2 cycles with all `in_req`=1 → `out_valid`=0, `out_data`=0, `out_chan`=0, `grant`=0 throughout. The first grant after release goes to channel 0 in round-robin mode.
- Manual mode: WIDTH=4, CHANNELS=4, `mode`=0, `sel`=2, `in_req`=4'b0100, ch2 data=4'hA, `out_ready`=1 → `grant`=4'b0100 in the cycle, then `out_data`=4'hA, `out_chan`=2, `out_valid`=1. Then set `in_req[2]`=0 → `out_valid`=0 one cycle later.
- Round-robin fairness: `mode`=1, `in_req`=4'b1111 constant, `out_ready`=1 → `out_chan` sequence 0,1,2,3,0,… with no idle cycles. With `in_req`=4'b1010 → 1,3,1,3.
- Backpressure: FULL with ch1 data=4'h5, `out_ready`=0 for 3 cycles while ch2 requests → `grant`=0, `out_data`=4'h5 held. Raise `out_ready` → ch2 is loaded at that same edge with no bubble.
- Mode switch and invalid select: with CHANNELS=3, `mode`=0, `sel`=3 → no grant ever. Switch to `mode`=1 after ch1 was last granted, with `in_req`=3'b111 → next grant goes to ch2.
- Reset mid-operation: FULL, stalled, pending requests, pulse `reset` for 1 cycle → outputs cleared and `ptr` reinitialised. The next grant goes to the lowest requesting channel.
